// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master command port between NREQ requesters.
// Define I2C_ARB_TIMEOUT_EN to enable the stalled-owner watchdog (forced STOP).
module i2c_bus_arbiter #(
    parameter int          NREQ           = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     gnt,
    input  logic [2*NREQ-1:0]   s_cmd,
    input  logic [8*NREQ-1:0]   s_data_in,
    input  logic [NREQ-1:0]     s_ack_in,
    input  logic [NREQ-1:0]     s_stb,
    output logic [NREQ-1:0]     s_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [7:0]          rsp_data,
    output logic                rsp_ack,
    output logic                rsp_err,
    output logic [1:0]          m_cmd,
    output logic [7:0]          m_data_in,
    output logic                m_ack_in,
    output logic                m_stb,
    input  logic                m_ready,
    input  logic [7:0]          m_data_out,
    input  logic                m_ack_out,
    input  logic                m_err_out,
    output logic [NREQ-1:0]     timeout_flag,
    output logic                busy
);

    localparam int IW = (NREQ > 2) ? 2 : 1;
    localparam logic [1:0] CMD_STOP = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FSTOP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      m_cmd_q, m_cmd_d;
    logic [7:0]      m_data_q, m_data_d;
    logic            m_ack_q, m_ack_d;
    logic            m_stb_q, m_stb_d;
    logic            blank_q, blank_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            rsp_ack_q, rsp_ack_d;
    logic            rsp_err_q, rsp_err_d;

    logic [IW-1:0]   pick_s;
    logic            pick_valid_s;
    logic [IW-1:0]   next_ptr_s;
    logic            own_stb_s;
    logic            own_req_s;
    logic            done_s;
    logic            timeout_fire_s;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [23:0]     cnt_q, cnt_d;
    logic [NREQ-1:0] tflag_q, tflag_d;
`else
    logic            unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    // Shared decode: round-robin pick, owner view and completion detection
    always_comb begin
        int j;
        j            = 0;
        pick_s       = '0;
        pick_valid_s = 1'b0;
        // Scan from the far end so the requester closest to the pointer wins
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end else begin
                j = j;
            end
            if (req[j]) begin
                pick_s       = IW'(j);
                pick_valid_s = 1'b1;
            end else begin
                pick_s       = pick_s;
            end
        end
        next_ptr_s = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
        own_stb_s  = s_stb[owner_q];
        own_req_s  = req[owner_q];
        // The master only drops ready after it sees the strobe, so two cycles are blanked
        done_s     = m_ready & ~m_stb_q & ~blank_q;
`ifdef I2C_ARB_TIMEOUT_EN
        timeout_fire_s = (cnt_q == (TIMEOUT_CYCLES - 24'd1)) && !own_stb_s;
`else
        timeout_fire_s = 1'b0;
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            m_cmd_q     <= 2'b00;
            m_data_q    <= 8'h00;
            m_ack_q     <= 1'b0;
            m_stb_q     <= 1'b0;
            blank_q     <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 8'h00;
            rsp_ack_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q       <= 24'd0;
            tflag_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            m_cmd_q     <= m_cmd_d;
            m_data_q    <= m_data_d;
            m_ack_q     <= m_ack_d;
            m_stb_q     <= m_stb_d;
            blank_q     <= blank_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ack_q   <= rsp_ack_d;
            rsp_err_q   <= rsp_err_d;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            tflag_q     <= tflag_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) state_d = ST_OWN;
                else              state_d = ST_IDLE;
            end
            ST_OWN: begin
                if (own_stb_s && m_ready) state_d = ST_WAIT;
                else if (!own_req_s)      state_d = ST_IDLE;
                else if (timeout_fire_s)  state_d = ST_FSTOP;
                else                      state_d = ST_OWN;
            end
            ST_WAIT: begin
                if (done_s) state_d = ST_OWN;
                else        state_d = ST_WAIT;
            end
            ST_FSTOP: begin
                if (done_s) state_d = ST_IDLE;
                else        state_d = ST_FSTOP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        m_cmd_d     = m_cmd_q;
        m_data_d    = m_data_q;
        m_ack_d     = m_ack_q;
        m_stb_d     = 1'b0;
        blank_d     = m_stb_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_ack_d   = rsp_ack_q;
        rsp_err_d   = rsp_err_q;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d       = 24'd0;
        tflag_d     = tflag_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    owner_d        = pick_s;
                    gnt_d          = '0;
                    gnt_d[pick_s]  = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                    tflag_d[pick_s] = 1'b0;
`endif
                end else begin
                    gnt_d = '0;
                end
            end
            ST_OWN: begin
                if (own_stb_s && m_ready) begin
                    m_cmd_d  = s_cmd[2*int'(owner_q) +: 2];
                    m_data_d = s_data_in[8*int'(owner_q) +: 8];
                    m_ack_d  = s_ack_in[owner_q];
                    m_stb_d  = 1'b1;
                end else if (!own_req_s) begin
                    gnt_d = '0;
                    ptr_d = next_ptr_s;
                end else if (timeout_fire_s) begin
                    m_cmd_d = CMD_STOP;
                    m_stb_d = 1'b1;
                    gnt_d   = '0;
`ifdef I2C_ARB_TIMEOUT_EN
                    tflag_d[owner_q] = 1'b1;
`endif
                end else begin
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt_d = own_stb_s ? 24'd0 : cnt_q + 24'd1;
`else
                    gnt_d = gnt_q;
`endif
                end
            end
            ST_WAIT: begin
                if (done_s) begin
                    rsp_data_d           = m_data_out;
                    rsp_ack_d            = m_ack_out;
                    rsp_err_d            = m_err_out;
                    rsp_valid_d[owner_q] = 1'b1;
                end else begin
                    rsp_valid_d = '0;
                end
            end
            ST_FSTOP: begin
                if (done_s) ptr_d = next_ptr_s;
                else        ptr_d = ptr_q;
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    // Only the owner sees the master's ready, and only while it may issue
    always_comb begin
        s_ready = '0;
        if (state_q == ST_OWN) s_ready[owner_q] = m_ready;
        else                   s_ready = '0;
    end

    assign gnt       = gnt_q;
    assign m_cmd     = m_cmd_q;
    assign m_data_in = m_data_q;
    assign m_ack_in  = m_ack_q;
    assign m_stb     = m_stb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ack   = rsp_ack_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef I2C_ARB_TIMEOUT_EN
    assign timeout_flag = tflag_q;
`else
    assign timeout_flag = '0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a simple i2c_master responder (4 busy cycles per command).
module tb_i2c_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, gnt, s_ack_in, s_stb, s_ready, rsp_valid, timeout_flag;
    logic [3:0]  s_cmd;
    logic [15:0] s_data_in;
    logic [7:0]  rsp_data, m_data_in, m_data_out;
    logic        rsp_ack, rsp_err, m_ack_in, m_stb, m_ready, m_ack_out, m_err_out, busy;
    logic [1:0]  m_cmd;

    int errors = 0;
    int checks = 0;
    int stb_cnt = 0;
    int rv0 = 0;
    int rv1 = 0;
    int mcnt = 0;
    logic [1:0]  cmd_log [0:7];
    logic [7:0]  data_log [0:7];

    i2c_bus_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(24'd16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .s_cmd(s_cmd), .s_data_in(s_data_in), .s_ack_in(s_ack_in), .s_stb(s_stb),
        .s_ready(s_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ack(rsp_ack), .rsp_err(rsp_err), .m_cmd(m_cmd), .m_data_in(m_data_in),
        .m_ack_in(m_ack_in), .m_stb(m_stb), .m_ready(m_ready), .m_data_out(m_data_out),
        .m_ack_out(m_ack_out), .m_err_out(m_err_out), .timeout_flag(timeout_flag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Master responder: drops ready on seeing a strobe, raises it 4 cycles later
    initial begin
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (m_stb) begin
                m_ready = 1'b0;
                mcnt = 4;
            end else if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) m_ready = 1'b1;
            end
        end
    end

    // Pulse monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_stb) begin
                if (stb_cnt < 8) begin
                    cmd_log[stb_cnt]  <= m_cmd;
                    data_log[stb_cnt] <= m_data_in;
                end
                stb_cnt <= stb_cnt + 1;
            end
            if (rsp_valid[0]) rv0 <= rv0 + 1;
            if (rsp_valid[1]) rv1 <= rv1 + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input int idx, input logic [1:0] cmd, input logic [7:0] d, input logic a);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (s_ready[idx]) found = 1'b1;
            else tick();
        end
        check("s_ready_wait", {31'd0, found}, 32'd1);
        s_cmd[2*idx +: 2]     = cmd;
        s_data_in[8*idx +: 8] = d;
        s_ack_in[idx]         = a;
        s_stb[idx]            = 1'b1;
        tick();
        s_stb[idx] = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (rsp_valid[idx]) found = 1'b1;
        end
        check("rsp_valid_wait", {31'd0, found}, 32'd1);
    endtask

    initial begin
        int   n;
        int   rv_before;
        logic found;
        rst_n = 1'b0; req = 2'b00; s_cmd = 4'h0; s_data_in = 16'h0000;
        s_ack_in = 2'b00; s_stb = 2'b00;
        m_data_out = 8'h00; m_ack_out = 1'b0; m_err_out = 1'b0;
        repeat (3) tick();
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_stb", {31'd0, m_stb}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data_in}, 32'd0);
        check("rst_tflag", {30'd0, timeout_flag}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Simultaneous requests resolved by pointer; re-request waits its turn
        req = 2'b11;
        check("rr_latency", {30'd0, gnt}, 32'd0);
        tick();
        check("rr_first", {30'd0, gnt}, 32'd1);
        check("rr_busy", {31'd0, busy}, 32'd1);
        req[0] = 1'b0;
        tick();
        check("rr_release", {30'd0, gnt}, 32'd0);
        req[0] = 1'b1;
        tick();
        check("rr_second", {30'd0, gnt}, 32'd2);
        repeat (3) tick();
        check("rr_hold", {30'd0, gnt}, 32'd2);
        req[1] = 1'b0;
        tick();
        check("rr_release1", {30'd0, gnt}, 32'd0);
        tick();
        check("rr_back0", {30'd0, gnt}, 32'd1);

        // Non-owner strobe ignored
        s_cmd = 4'b1000; s_data_in = 16'h5500; s_stb = 2'b10;
        check("nonowner_ready", {30'd0, s_ready}, 32'd1);
        repeat (3) tick();
        s_stb = 2'b00;
        repeat (3) tick();
        check("nonowner_stb", stb_cnt, 32'd0);
        check("nonowner_data", {24'd0, m_data_in}, 32'd0);
        check("nonowner_rsp", rv1, 32'd0);
        check("nonowner_gnt", {30'd0, gnt}, 32'd1);
        req = 2'b00;
        tick();
        check("nonowner_idle", {31'd0, busy}, 32'd0);

        // START / WRITE 0x30 / STOP from requester 0
        m_ack_out = 1'b1; m_data_out = 8'h3C;
        req = 2'b01;
        tick();
        check("t1_gnt", {30'd0, gnt}, 32'd1);
        do_cmd(0, 2'b00, 8'h00, 1'b1);
        do_cmd(0, 2'b10, 8'h30, 1'b1);
        do_cmd(0, 2'b01, 8'h00, 1'b1);
        tick();
        check("t1_stb_cnt", stb_cnt, 32'd3);
        check("t1_cmd0", {30'd0, cmd_log[0]}, 32'd0);
        check("t1_cmd1", {30'd0, cmd_log[1]}, 32'd2);
        check("t1_data1", {24'd0, data_log[1]}, 32'h30);
        check("t1_cmd2", {30'd0, cmd_log[2]}, 32'd1);
        check("t1_rv0", rv0, 32'd3);
        check("t1_rv1", rv1, 32'd0);
        check("t1_rsp_ack", {31'd0, rsp_ack}, 32'd1);
        check("t1_rsp_data", {24'd0, rsp_data}, 32'h3C);
        req = 2'b00;
        tick();
        check("t1_release", {30'd0, gnt}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // READ returning 0xA5
        m_data_out = 8'hA5; m_ack_out = 1'b0; m_err_out = 1'b0;
        req = 2'b01;
        tick();
        check("rd_gnt", {30'd0, gnt}, 32'd1);
        do_cmd(0, 2'b11, 8'h00, 1'b0);
        check("rd_valid", {30'd0, rsp_valid}, 32'd1);
        check("rd_data", {24'd0, rsp_data}, 32'hA5);
        check("rd_ack", {31'd0, rsp_ack}, 32'd0);
        check("rd_err", {31'd0, rsp_err}, 32'd0);
        check("rd_m_cmd", {30'd0, m_cmd}, 32'd3);
        check("rd_m_ack_in", {31'd0, m_ack_in}, 32'd0);
        m_data_out = 8'h11; m_ack_out = 1'b1; m_err_out = 1'b1;
        repeat (3) tick();
        check("rd_hold_data", {24'd0, rsp_data}, 32'hA5);
        check("rd_hold_ack", {31'd0, rsp_ack}, 32'd0);
        check("rd_hold_err", {31'd0, rsp_err}, 32'd0);
        check("rd_single", rv0, 32'd4);
        req = 2'b00;
        tick();

        // Silent owner: watchdog or indefinite hold
        req = 2'b10;
        tick();
        check("wd_gnt", {30'd0, gnt}, 32'd2);
        n = stb_cnt;
`ifdef I2C_ARB_TIMEOUT_EN
        n = 0;
        while (!m_stb && n < 40) begin
            tick();
            n++;
        end
        check("wd_cycles", n, 32'd16);
        check("wd_cmd", {30'd0, m_cmd}, 32'd1);
        check("wd_gnt_clr", {30'd0, gnt}, 32'd0);
        check("wd_flag", {30'd0, timeout_flag}, 32'd2);
        rv_before = rv1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (gnt == 2'b10) found = 1'b1;
        end
        check("wd_regrant", {31'd0, found}, 32'd1);
        check("wd_flag_clr", {30'd0, timeout_flag}, 32'd0);
        check("wd_no_rsp", rv1, rv_before);
`else
        repeat (40) tick();
        check("stall_gnt", {30'd0, gnt}, 32'd2);
        check("stall_stb", stb_cnt, n);
        check("stall_flag", {30'd0, timeout_flag}, 32'd0);
        check("stall_busy", {31'd0, busy}, 32'd1);
`endif
        req = 2'b00;
        tick();

        // Reset in WAIT; pointer must return to requester 0
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        req = 2'b01;
        tick();
        check("rs_gnt", {30'd0, gnt}, 32'd1);
        s_cmd[1:0] = 2'b10; s_data_in[7:0] = 8'h77; s_stb = 2'b01;
        tick();
        s_stb = 2'b00;
        check("rs_stb", {31'd0, m_stb}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rs_async_gnt", {30'd0, gnt}, 32'd0);
        check("rs_async_stb", {31'd0, m_stb}, 32'd0);
        check("rs_async_busy", {31'd0, busy}, 32'd0);
        check("rs_async_rsp", {30'd0, rsp_valid}, 32'd0);
        check("rs_async_data", {24'd0, m_data_in}, 32'd0);
        req = 2'b11;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rs_ptr0", {30'd0, gnt}, 32'd1);
        req = 2'b00;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
